// File: rtl/rl_ram_1r1w_clr.sv
// 1R1W byte-enabled RAM with whole-array clear sequencer and optional output register.
// Define RL_RAM_1R1W_BYPASS_EN to forward same-cycle write data to a same-address read.
module rl_ram_1r1w_clr #(
    parameter int unsigned ABITS  = 10,
    parameter int unsigned DBITS  = 32,
    parameter int unsigned OUTREG = 0
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         clr_i,
    output logic                         busy_o,
    input  logic [ABITS-1:0]             waddr_i,
    input  logic [DBITS-1:0]             din_i,
    input  logic                         we_i,
    input  logic [((DBITS+7)/8)-1:0]     be_i,
    input  logic                         re_i,
    input  logic [ABITS-1:0]             raddr_i,
    output logic [DBITS-1:0]             dout_o,
    output logic                         dvalid_o
);

    localparam int unsigned DEPTH = 1 << ABITS;

    typedef enum logic {
        IDLE,
        CLEAR
    } state_e;

    state_e             state_q, state_d;
    logic [ABITS-1:0]   cnt_q, cnt_d;
    logic [DBITS-1:0]   mem_q [DEPTH];
    logic [DBITS-1:0]   wmask;
    logic [DBITS-1:0]   wr_word;
    logic [DBITS-1:0]   rd_word;
    logic               wr_en;
    logic               rd_en;
    logic [DBITS-1:0]   r1_q;
    logic               v1_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (clr_i) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                cnt_d = cnt_q + ABITS'(1);
                if (cnt_q == '1) begin
                    state_d = IDLE;
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    always_comb begin
        busy_o = (state_q == CLEAR);
    end

    // Expand byte enables to a per-bit mask; the top lane may be narrower than 8 bits.
    always_comb begin
        wmask = '0;
        for (int unsigned b = 0; b < DBITS; b++) begin
            wmask[b] = be_i[b / 8];
        end
    end

    assign wr_en   = we_i && !busy_o && !rst_i;
    assign rd_en   = re_i && !busy_o && !rst_i;
    assign wr_word = (mem_q[waddr_i] & ~wmask) | (din_i & wmask);

`ifdef RL_RAM_1R1W_BYPASS_EN
    assign rd_word = (wr_en && (waddr_i == raddr_i)) ? wr_word : mem_q[raddr_i];
`else
    assign rd_word = mem_q[raddr_i];
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_i && state_q == CLEAR) begin
            mem_q[cnt_q] <= '0;
        end else if (wr_en) begin
            mem_q[waddr_i] <= wr_word;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r1_q <= '0;
            v1_q <= 1'b0;
        end else begin
            v1_q <= rd_en;
            if (rd_en) begin
                r1_q <= rd_word;
            end
        end
    end

    // Second stage does not look at busy_o so an in-flight read survives a clear start.
    if (OUTREG != 0) begin : g_outreg
        logic [DBITS-1:0] r2_q;
        logic             v2_q;

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                r2_q <= '0;
                v2_q <= 1'b0;
            end else begin
                v2_q <= v1_q;
                if (v1_q) begin
                    r2_q <= r1_q;
                end
            end
        end

        assign dout_o   = r2_q;
        assign dvalid_o = v2_q;
    end else begin : g_noreg
        assign dout_o   = r1_q;
        assign dvalid_o = v1_q;
    end

endmodule
